// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// Requests are arbitrated round-robin, operands are registered and presented
// to the ALU for one cycle, and the captured result is held until the granted
// requester takes it.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_PASS = 3'b100;

  state_t     state;
  state_t     state_nxt;
  logic       grant;
  logic       last_grant;
  logic       pick;
  logic       accept;
  logic       rsp_done;
  logic       ill_p0;
  logic [2:0] sel_op;

  // Opcodes above pass-A have no ALU meaning and are answered with an error.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_PASS;
  endfunction

  assign sel_op    = pick ? req1_op : req0_op;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP) ? {grant, ~grant} : 2'b00;

  // Next state, arbitration and handshakes; readies are held low during reset.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    pick       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    case (state)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~pick;
          req1_ready = pick;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready[grant]) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant is recorded at acceptance; round-robin history moves on delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept)   grant      <= pick;
      if (rsp_done) last_grant <= grant;
    end
  end

  // Operand stage (p0): the only source of the ALU drive; illegal ops run as pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      ill_p0 <= 1'b0;
    end else if (accept) begin
      alu_a  <= pick ? req1_a : req0_a;
      alu_b  <= pick ? req1_b : req0_b;
      alu_op <= op_legal(sel_op) ? sel_op : OP_PASS;
      ill_p0 <= ~op_legal(sel_op);
    end
  end

  // Result stage (p1): ALU outputs captured during the single EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state == EXEC) begin
      if (ill_p0) begin
        rsp_data <= '0;
        rsp_zero <= 1'b0;
        rsp_neg  <= 1'b0;
        rsp_err  <= 1'b1;
      end else begin
        rsp_data <= alu_out;
        rsp_zero <= alu_zero;
        rsp_neg  <= alu_neg;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: behavioural ALU, randomized requesters with a
// scoreboard queue, and a monitor that checks every presented response.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_neg, rsp_err;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_neg, busy;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared ALU: purely combinational, driven by the arbiter's operand registers.
  always_comb begin
    case (alu_op)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a + 32'd1;
      3'b010:  alu_out = ~alu_a + 32'd1;
      3'b011:  alu_out = alu_b + ~alu_a + 32'd1;
      3'b100:  alu_out = alu_a;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_out == 32'd0);
    alu_neg  = alu_out[31];
  end

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        zero;
    logic        neg;
    logic        err;
    logic [31:0] acc;
    logic        seen;
  } exp_t;

  exp_t        sbq[$];
  logic        grant_log[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          pend [2];
  logic [2:0]  p_op [2];
  logic [31:0] p_a  [2];
  logic [31:0] p_b  [2];
  int          wait_cnt [2];
  bit          gen_en, auto_refill, model_last;
  int          rr_mode;
  logic [1:0]  lr_valid;
  logic [31:0] lr_data;
  logic        lr_zero, lr_neg, lr_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Reference: the architected result of one operation, straight from the opcode table.
  function automatic exp_t ref_rsp(input logic id, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] acc);
    exp_t e;
    e     = '0;
    e.id  = id;
    e.acc = acc;
    case (op)
      3'd0:    e.data = a + b;
      3'd1:    e.data = a + 32'd1;
      3'd2:    e.data = 32'd0 - a;
      3'd3:    e.data = b - a;
      3'd4:    e.data = a;
      default: e.err  = 1'b1;
    endcase
    e.zero = !e.err && (e.data == 32'd0);
    e.neg  = !e.err && e.data[31];
    return e;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    pend[n]     = 1'b1;
    p_op[n]     = op;
    p_a[n]      = a;
    p_b[n]      = b;
    wait_cnt[n] = 0;
  endtask

  // Requesters: drive pending requests, check acceptance rules, push expectations.
  initial begin : stim
    logic w;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    forever begin
      @(negedge clk);
      if (gen_en)
        for (int n = 0; n < 2; n++)
          if (!pend[n] && $urandom_range(0, 2) == 0)
            set_req(n, 3'($urandom_range(0, 7)), rnd_val(), rnd_val());
      req0_valid = pend[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
      req1_valid = pend[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
      #1;
      if (rst_n) begin
        check("busy_vs_inflight", 64'(busy), 64'(sbq.size() != 0));
        if (sbq.size() == 0 && (pend[0] || pend[1]))
          check("ready_when_idle", 64'(req0_ready | req1_ready), 64'(1));
        if (req0_ready || req1_ready) begin
          w = req1_ready;
          check("ready_onehot", 64'(req0_ready & req1_ready), 64'(0));
          check("ready_needs_valid", 64'(pend[w]), 64'(1));
          check("accept_when_idle", 64'(sbq.size()), 64'(0));
          if (pend[0] && pend[1]) check("rr_grant", 64'(w), 64'(!model_last));
          sbq.push_back(ref_rsp(w, p_op[w], p_a[w], p_b[w], 32'(cyc)));
          grant_log.push_back(w);
          if (auto_refill && grant_log.size() < 4)
            set_req(int'(w), 3'($urandom_range(0, 4)), $urandom, $urandom);
          else
            pend[w] = 1'b0;
        end
        for (int n = 0; n < 2; n++)
          if (pend[n]) begin
            wait_cnt[n]++;
            if (wait_cnt[n] > 60) begin
              timeout("req_starved");
              pend[n] = 1'b0;
            end
          end
      end
    end
  end

  // Monitor: compare each presented response with the scoreboard head, drive rsp_ready.
  initial begin : mon
    exp_t e;
    rsp_ready = 2'b00;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        rsp_ready = 2'b00;
      end else begin
        check("alu_op_legal", 64'(alu_op <= 3'd4), 64'(1));
        if (rsp_valid != 2'b00) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected: rsp_valid=%b with nothing in flight", rsp_valid);
            rsp_ready = 2'b00;
          end else begin
            e = sbq[0];
            check("rsp_valid", 64'(rsp_valid), 64'(e.id ? 2'b10 : 2'b01));
            check("rsp_payload", 64'({rsp_data, rsp_zero, rsp_neg, rsp_err}),
                  64'({e.data, e.zero, e.neg, e.err}));
            if (!e.seen) begin
              check("rsp_latency", 64'(cyc - int'(e.acc)), 64'(2));
              e.seen = 1'b1;
              sbq[0] = e;
            end
            case (rr_mode)
              0:       rsp_ready = 2'($urandom_range(0, 3));
              1:       rsp_ready = 2'b11;
              default: rsp_ready = e.id ? 2'b01 : 2'b10;
            endcase
            if (rsp_ready[e.id]) begin
              void'(sbq.pop_front());
              model_last = e.id;
              lr_valid   = rsp_valid;
              lr_data    = rsp_data;
              lr_zero    = rsp_zero;
              lr_neg     = rsp_neg;
              lr_err     = rsp_err;
            end
          end
        end else begin
          rsp_ready = (rr_mode == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    sbq.delete();
    model_last = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_accept(input int n);
    for (int i = 0; i < 20 && pend[n]; i++) begin
      @(posedge clk); #3;
    end
    if (pend[n]) timeout("wait_accept");
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (pend[0] || pend[1] || sbq.size() != 0); i++) begin
      @(posedge clk); #3;
    end
    if (pend[0] || pend[1] || sbq.size() != 0) timeout("drain");
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, 64'({req0_ready, req1_ready}), 64'(0));
    check({name, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_rsp"}, 64'({rsp_data, rsp_zero, rsp_neg, rsp_err}), 64'(0));
    check({name, "_alu"}, 64'({alu_a, alu_op}), 64'(0));
    check({name, "_alu_b"}, 64'(alu_b), 64'(0));
  endtask

  initial begin : main
    gen_en = 1'b0; auto_refill = 1'b0; rr_mode = 1; model_last = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Subtract is B - A.
    set_req(0, 3'b011, 32'd5, 32'd12);
    drain();
    check("d1_valid", 64'(lr_valid), 64'(2'b01));
    check("d1_data", 64'({lr_data, lr_zero, lr_neg, lr_err}), 64'({32'd7, 3'b000}));

    // Increment wraps to zero.
    set_req(1, 3'b001, 32'hFFFF_FFFF, 32'd0);
    drain();
    check("d2_valid", 64'(lr_valid), 64'(2'b10));
    check("d2_data", 64'({lr_data, lr_zero, lr_neg, lr_err}), 64'({32'd0, 3'b100}));

    // Negate.
    set_req(0, 3'b010, 32'd5, 32'd0);
    drain();
    check("d3_data", 64'({lr_data, lr_zero, lr_neg, lr_err}), 64'({32'hFFFF_FFFB, 3'b010}));

    // Continuous contention after reset alternates 0,1,0,1.
    do_reset();
    grant_log.delete();
    auto_refill = 1'b1;
    set_req(0, 3'b000, $urandom, $urandom);
    set_req(1, 3'b100, $urandom, $urandom);
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) begin
      @(posedge clk); #3;
    end
    auto_refill = 1'b0;
    drain();
    if (grant_log.size() < 4) timeout("d4_grants");
    else begin
      check("d4_grant0", 64'(grant_log[0]), 64'(0));
      check("d4_grant1", 64'(grant_log[1]), 64'(1));
      check("d4_grant2", 64'(grant_log[2]), 64'(0));
      check("d4_grant3", 64'(grant_log[3]), 64'(1));
    end

    // Illegal opcode with a stalled consumer; req1 must wait.
    rr_mode = 2;
    set_req(0, 3'b111, $urandom | 32'd1, $urandom);
    wait_accept(0);
    set_req(1, 3'b000, 32'd3, 32'd4);
    for (int i = 0; i < 10 && rsp_valid == 2'b00; i++) begin
      @(posedge clk); #3;
    end
    repeat (5) begin
      @(posedge clk); #3;
      check("d5_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      check("d5_busy", 64'(busy), 64'(1));
      check("d5_payload", 64'({rsp_data, rsp_zero, rsp_neg, rsp_err}), 64'({32'd0, 3'b001}));
      check("d5_req1_ready", 64'(req1_ready), 64'(0));
    end
    rr_mode = 1;
    drain();
    check("d5_last", 64'({lr_valid, lr_data, lr_zero, lr_neg, lr_err}), 64'({2'b10, 32'd7, 3'b000}));

    // Reset during EXEC drops the transaction.
    set_req(0, 3'b000, 32'h0000_0F00, 32'd7);
    wait_accept(0);
    check("d6_in_exec", 64'({busy, rsp_valid}), 64'({1'b1, 2'b00}));
    rst_n = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    sbq.delete();
    model_last = 1'b1;
    #1 check_all_zero("d6_async");
    @(posedge clk); #3;
    check_all_zero("d6_next");
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #3;
      check("d6_idle", 64'({busy, rsp_valid}), 64'(0));
    end
    set_req(1, 3'b100, 32'h1234_5678, 32'd0);
    drain();
    check("d6_after", 64'({lr_valid, lr_data, lr_err}), 64'({2'b10, 32'h1234_5678, 1'b0}));

    // Randomized traffic with random consumer back-pressure.
    rr_mode = 0;
    gen_en  = 1'b1;
    repeat (3000) @(posedge clk);
    #3 gen_en = 1'b0;
    rr_mode = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
